adder_seq_ctrl: RTL and testbench
=================================

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 16: total operand width in bits.
REQ-002 The block SHALL have parameter W, default 4: width of the single shared adder slice in bits.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  request to begin an addition, sampled on clk.
REQ-006 The block SHALL have port P  input  N  first operand.
REQ-007 The block SHALL have port Q  input  N  second operand.
REQ-008 The block SHALL have port Cin  input  1  carry in.
REQ-009 The block SHALL have port busy  output  1  high while an addition is in progress.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-011 The block SHALL have port SUM  output  N  result, held until the next accepted start.
REQ-012 The block SHALL have port Cout  output  1  final carry out, held with SUM.

Function
REQ-013 The block SHALL implement states IDLE, RUN and DONE.
REQ-014 start SHALL be accepted only in IDLE; start in RUN or DONE SHALL be ignored with no side effects.
REQ-015 On an accepted start, P, Q and Cin SHALL be registered, the slice index cleared to 0, SUM cleared, and the state set to RUN; input changes after that edge SHALL NOT affect the result.
REQ-016 In RUN, each cycle SHALL add slice i of registered P and Q plus the carry register, write the W-bit sum into SUM[i*W +: W], and load the slice carry-out into the carry register.
REQ-017 The carry register SHALL be loaded from the registered Cin on the accepting edge.
REQ-018 RUN SHALL last exactly N/W cycles; on the edge that completes slice N/W-1, the state SHALL become DONE and Cout SHALL take the final carry.
REQ-019 The DONE state SHALL last one cycle, with done=1, then return to IDLE.
REQ-020 Latency SHALL be N/W+1 edges from the start-sampling edge to done high; with the defaults this is 5.
REQ-021 busy SHALL be high exactly in RUN; done SHALL be high exactly in DONE.
REQ-022 {Cout,SUM} SHALL equal P+Q+Cin, computed as an (N+1)-bit integer sum of the registered values, with wrap-around into Cout.
REQ-023 Back-to-back operation SHALL be possible: start held high SHALL be accepted in the IDLE cycle following DONE.
REQ-024 N not a multiple of W, or W>N, SHALL cause an elaboration error.

Reset
REQ-025 Asserting reset SHALL immediately force IDLE, with busy=0, done=0, SUM=0, Cout=0, and the carry register, slice index and operand registers cleared.
REQ-026 Reset asserted in mid-operation SHALL abandon the addition; no done pulse SHALL follow deassertion.
REQ-027 After reset deasserts, the first start sampled in IDLE SHALL be accepted normally.

Structure
REQ-028 A shared package adder_pkg SHALL hold the state enum (IDLE, RUN, DONE) and default constants N_DEF=16 and W_DEF=4.
REQ-029 The datapath SHALL instantiate exactly one adder_N sub-module with its N parameter set to W; it SHALL be the only adder used.
REQ-030 The slice index counter SHALL be $clog2(N/W) bits wide, minimum 1.

Verification
REQ-031 P=16'h00FF, Q=16'h0001, Cin=0 -> done on the 5th edge after start; SUM=16'h0100, Cout=0.
REQ-032 P=16'hFFFF, Q=16'h0000, Cin=1 -> SUM=16'h0000, Cout=1; busy high for exactly 4 cycles.
REQ-033 start pulsed again in RUN and DONE, with P/Q changed during RUN -> first result unaffected; only one done pulse.
REQ-034 reset asserted on the 2nd RUN cycle -> outputs zero at once; no done pulse; the next start completes correctly.
REQ-035 start held high continuously with a new operand pair each IDLE cycle -> one done per 6 cycles, each result correct.
REQ-036 500 random P/Q/Cin triples -> every {Cout,SUM} equals the integer sum P+Q+Cin.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state encoding and default sizes for the sliced adder
package adder_pkg;

    localparam int N_DEF = 16;
    localparam int W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/adder_N.sv
// rtl/adder_N.sv - N-bit combinational adder with carry in and carry out
module adder_N #(
    parameter int N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic [N:0] total;

    // Widen by one bit so the carry out falls out of the top of the sum.
    assign total            = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};
    assign {cout_o, sum_o}  = total;

endmodule

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - N-bit addition performed W bits per cycle on one shared adder slice
module adder_seq_ctrl
    import adder_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] P,
    input  logic [N-1:0] Q,
    input  logic         Cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] SUM,
    output logic         Cout
);

    // Guarded so an illegal W still lets the error below be reported cleanly.
    localparam int SLICES = ((W > 0) && (W <= N)) ? (N / W) : 1;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    if ((W > N) || ((N % W) != 0)) begin : g_bad_params
        $error("adder_seq_ctrl: N (%0d) must be a positive multiple of W (%0d)", N, W);
    end

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [N-1:0]     p_q;
    logic [N-1:0]     q_q;
    logic [N-1:0]     sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic [W-1:0]     slice_p;
    logic [W-1:0]     slice_q;
    logic [W-1:0]     slice_sum;
    logic             slice_cout;

    // Select the operand slices addressed by the current slice index.
    always_comb begin
        slice_p = '0;
        slice_q = '0;
        for (int s = 0; s < SLICES; s++) begin
            if (idx_q == IDX_W'(s)) begin
                slice_p = p_q[s*W +: W];
                slice_q = q_q[s*W +: W];
            end
        end
    end

    adder_N #(
        .N (W)
    ) u_slice_adder (
        .a_i    (slice_p),
        .b_i    (slice_q),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    // Control FSM and datapath registers; outputs are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        p_q     <= P;
                        q_q     <= Q;
                        carry_q <= Cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    for (int s = 0; s < SLICES; s++) begin
                        if (idx_q == IDX_W'(s)) begin
                            sum_q[s*W +: W] <= slice_sum;
                        end
                    end
                    carry_q <= slice_cout;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= slice_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign SUM  = sum_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb/tb_adder_seq_ctrl.sv - self-checking bench for the sequential sliced adder
module tb_adder_seq_ctrl;

    localparam int N   = 16;
    localparam int W   = 4;
    localparam int LAT = N / W;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [N-1:0]  P;
    logic [N-1:0]  Q;
    logic          Cin;
    logic          busy;
    logic          done;
    logic [N-1:0]  SUM;
    logic          Cout;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    adder_seq_ctrl #(
        .N (N),
        .W (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .P     (P),
        .Q     (Q),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .SUM   (SUM),
        .Cout  (Cout)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [N-1:0] p, input logic [N-1:0] q, input logic c,
                          input bit disturb, input string tag);
        logic [N:0] exp;
        int         lat;
        int         busy_cnt;
        bit         seen;
        exp = {1'b0, p} + {1'b0, q} + (N+1)'(c);
        check_eq({tag, "_idle"}, {busy, done}, 2'b00);
        P     = p;
        Q     = q;
        Cin   = c;
        start = 1'b1;
        step();
        check_eq({tag, "_sum_clr"}, SUM, '0);
        check_eq({tag, "_busy_on"}, busy, 1'b1);
        lat      = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        while (!seen && lat < 20) begin
            if (disturb) begin
                P     = N'($urandom);
                Q     = N'($urandom);
                Cin   = 1'($urandom_range(0, 1));
                start = (lat == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            step();
            lat++;
            if (done) seen = 1'b1;
        end
        check_eq({tag, "_done_seen"}, seen, 1'b1);
        check_eq({tag, "_latency"}, lat, LAT);
        check_eq({tag, "_busy_cycles"}, busy_cnt, LAT);
        check_eq({tag, "_busy_in_done"}, busy, 1'b0);
        check_eq({tag, "_sum"}, SUM, exp[N-1:0]);
        check_eq({tag, "_cout"}, Cout, exp[N]);
        start = disturb ? 1'b1 : 1'b0;
        step();
        start = 1'b0;
        check_eq({tag, "_done_pulse"}, {busy, done}, 2'b00);
        check_eq({tag, "_held"}, {Cout, SUM}, exp);
        step();
        check_eq({tag, "_stay_idle"}, {busy, done}, 2'b00);
    endtask

    logic [N-1:0] ap [64];
    logic [N-1:0] aq [64];
    logic         ac [64];

    initial begin
        logic [N:0] exp;
        int         nd;
        int         phase;

        reset = 1'b1;
        start = 1'b0;
        P     = '0;
        Q     = '0;
        Cin   = 1'b0;
        step();
        step();
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_sum", SUM, '0);
        check_eq("rst_cout", Cout, 1'b0);
        reset = 1'b0;
        step();

        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, "basic");
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, "wrap");
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, "top_carry");
        run_op(16'h1234, 16'hABCD, 1'b1, 1'b1, "disturb");

        // Abort on the second RUN cycle; outputs must clear before any clock edge.
        P     = 16'h1234;
        Q     = 16'h1111;
        Cin   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_done", done, 1'b0);
        check_eq("abort_sum", SUM, '0);
        check_eq("abort_cout", Cout, 1'b0);
        step();
        reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) nd++;
        end
        check_eq("abort_no_done", nd, 0);
        run_op(16'h0F0F, 16'hF0F1, 1'b0, 1'b0, "after_abort");

        // Start held high: acceptances land every LAT+2 edges.
        start = 1'b1;
        nd    = 0;
        for (int c = 0; c < 6 * (LAT + 2); c++) begin
            ap[c] = N'($urandom);
            aq[c] = N'($urandom);
            ac[c] = 1'($urandom_range(0, 1));
            P     = ap[c];
            Q     = aq[c];
            Cin   = ac[c];
            step();
            phase = c % (LAT + 2);
            check_eq("b2b_busy", busy, (phase < LAT));
            check_eq("b2b_done", done, (phase == LAT));
            if (phase == LAT) begin
                exp = {1'b0, ap[c-LAT]} + {1'b0, aq[c-LAT]} + (N+1)'(ac[c-LAT]);
                check_eq("b2b_result", {Cout, SUM}, exp);
                nd++;
            end
        end
        start = 1'b0;
        check_eq("b2b_count", nd, 6);
        step();

        for (int k = 0; k < 500; k++) begin
            run_op(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)), 1'b0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
